// File: rtl/uart_iot_stream_tx.sv
// uart_iot_stream_tx
//   Buffers SAMPLE_W-bit samples in a FIFO. Once FRAME_SAMPLES samples are queued, it
//   streams one AT frame over an 8N1 UART: "AT+TX=" + uppercase hex payload + "\r\n".
//   Samples are hex-encoded one nibble per character while the frame is sent, so no
//   frame-wide buffer is needed.
// Optional feature (compile-time macro UART_IOT_CSUM_EN):
//   appends the XOR of all payload characters as two hex characters before "\r\n".
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   en         allow new frames to start
//   s_data     sample input
//   s_valid    s_data valid
//   s_ready    FIFO can accept a sample (registered, = !full)
//   tx         UART serial output, idle high (registered)
//   busy       high from frame start until frame_done (registered)
//   frame_done one-cycle pulse after the final stop bit of a frame (registered)
module uart_iot_stream_tx #(
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned FRAME_SAMPLES = 240,
  parameter int unsigned FIFO_DEPTH    = 256,
  parameter int unsigned CLKS_PER_BIT  = 434
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                tx,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned NIBS   = SAMPLE_W / 4;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(((NIBS > 6) ? NIBS : 6) + 1);
  localparam int unsigned SCNT_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

`ifdef UART_IOT_CSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, PAY, CSUM, TRL, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, PAY, TRL, DONE} state_t;
`endif

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  logic                push;
  logic                pop_c;
  logic [SAMPLE_W-1:0] head;

  // s_ready is registered, so a pop in a full cycle cannot enable a push
  assign push = s_valid && s_ready;
  assign head = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    if (push && !pop_c) begin
      count_next = count + CNT_W'(1);
    end else if (!push && pop_c) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers, count and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count   <= count_next;
      s_ready <= (count_next < CNT_W'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter (8N1, LSB first)
  // ---------------------------------------------------------------------------
  logic [9:0]        shreg;
  logic [3:0]        bit_idx;
  logic [BAUD_W-1:0] baud_cnt;
  logic              active;
  logic              uart_free_c;
  logic              load_c;
  logic [7:0]        byte_c;

  // Free when idle or in the last cycle of the stop bit, so bytes chain gap-free
  assign uart_free_c = !active ||
                       ((baud_cnt == BAUD_W'(CLKS_PER_BIT - 1)) && (bit_idx == 4'd9));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '1;
      bit_idx  <= '0;
      baud_cnt <= '0;
      active   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx <= active ? shreg[0] : 1'b1;
      if (load_c) begin
        shreg    <= {1'b1, byte_c, 1'b0};
        bit_idx  <= '0;
        baud_cnt <= '0;
        active   <= 1'b1;
      end else if (active) begin
        if (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1)) begin
          baud_cnt <= '0;
          if (bit_idx == 4'd9) begin
            active <= 1'b0;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            shreg   <= {1'b1, shreg[9:1]};
          end
        end else begin
          baud_cnt <= baud_cnt + BAUD_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [SCNT_W-1:0] scnt;
  logic [3:0]        nibble;
  logic              last_nib_c;
  int unsigned       sh_amt;
`ifdef UART_IOT_CSUM_EN
  logic [7:0]        csum;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  // "AT+TX="
  function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] i);
    case (i)
      IDX_W'(0): hdr_byte = 8'h41;
      IDX_W'(1): hdr_byte = 8'h54;
      IDX_W'(2): hdr_byte = 8'h2B;
      IDX_W'(3): hdr_byte = 8'h54;
      IDX_W'(4): hdr_byte = 8'h58;
      default:   hdr_byte = 8'h3D;
    endcase
  endfunction

  // Character selection and UART load / FIFO pop strobes
  always_comb begin
    load_c     = 1'b0;
    byte_c     = 8'h00;
    pop_c      = 1'b0;
    sh_amt     = 4 * (NIBS - 1 - 32'(idx));
    nibble     = 4'(head >> sh_amt);
    last_nib_c = (idx == IDX_W'(NIBS - 1));
    case (state)
      HDR: begin
        load_c = uart_free_c;
        byte_c = hdr_byte(idx);
      end
      PAY: begin
        load_c = uart_free_c;
        byte_c = hex_char(nibble);
        // Sample leaves the FIFO when its last character goes to the UART
        pop_c  = uart_free_c && last_nib_c;
      end
`ifdef UART_IOT_CSUM_EN
      CSUM: begin
        load_c = uart_free_c;
        byte_c = (idx == '0) ? hex_char(csum[7:4]) : hex_char(csum[3:0]);
      end
`endif
      TRL: begin
        load_c = uart_free_c && (idx < IDX_W'(2));
        byte_c = (idx == '0) ? 8'h0D : 8'h0A;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      scnt       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_IOT_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en && (count >= CNT_W'(FRAME_SAMPLES))) begin
            state <= HDR;
            busy  <= 1'b1;
            idx   <= '0;
            scnt  <= '0;
`ifdef UART_IOT_CSUM_EN
            csum  <= '0;
`endif
          end
        end
        HDR: begin
          if (load_c) begin
            if (idx == IDX_W'(5)) begin
              idx   <= '0;
              state <= PAY;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        PAY: begin
          if (load_c) begin
`ifdef UART_IOT_CSUM_EN
            csum <= csum ^ byte_c;
`endif
            if (last_nib_c) begin
              idx <= '0;
              if (scnt == SCNT_W'(FRAME_SAMPLES - 1)) begin
                scnt <= '0;
`ifdef UART_IOT_CSUM_EN
                state <= CSUM;
`else
                state <= TRL;
`endif
              end else begin
                scnt <= scnt + SCNT_W'(1);
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
`ifdef UART_IOT_CSUM_EN
        CSUM: begin
          if (load_c) begin
            if (idx == IDX_W'(1)) begin
              idx   <= '0;
              state <= TRL;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
`endif
        TRL: begin
          // After "\n" is loaded, wait for its stop bit to finish
          if (load_c) begin
            idx <= idx + IDX_W'(1);
          end else if (uart_free_c && (idx == IDX_W'(2))) begin
            idx   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
